// File: rtl/mem_port_req_queue_if.sv
// -----------------------------------------------------------------------------
// mem_port_req_queue_if
//   Shared memory bus seen by the CGRA memory-port request queue.
//   The request channel uses a valid/ready handshake. The read response channel
//   has a valid strobe only, because at most one read is ever outstanding.
//
//   Signals
//     mem_req_valid   request valid (queue -> memory)
//     mem_req_ready   memory accepts the request (memory -> queue)
//     mem_req_we      1 = write, 0 = read
//     mem_req_addr    request address
//     mem_req_wdata   write data
//     mem_resp_valid  read response valid (memory -> queue)
//     mem_resp_rdata  read response data
//
//   Modports
//     master  the request queue (drives the request channel)
//     slave   the memory / bus model (drives ready and the response channel)
// -----------------------------------------------------------------------------
interface mem_port_req_queue_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_rdata;

    modport master (
        output mem_req_valid,
        output mem_req_we,
        output mem_req_addr,
        output mem_req_wdata,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_rdata
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_we,
        input  mem_req_addr,
        input  mem_req_wdata,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_rdata
    );

endinterface

// File: rtl/mem_port_req_queue.sv
// -----------------------------------------------------------------------------
// mem_port_req_queue
//   Sits directly downstream of a CGRA memory port. On every Enable it captures
//   one request {write_rq, addr, to_mem} into a DEPTH-entry FIFO. Requests are
//   issued in order to the shared memory bus. A read blocks further issue
//   until its response returns, so at most one read is ever outstanding. The
//   returned read data is held on from_mem. stall freezes the array while
//   the FIFO is full.
//
//   Ports
//     Clock      rising-edge clock
//     Reset      synchronous, active-high; flushes the FIFO and all state
//     Enable     CGRA step: sample the port request this cycle
//     addr       request address
//     to_mem     request write data
//     write_rq   1 = write, 0 = read
//     from_mem   last read data (registered, held)
//     rd_valid   one-cycle pulse when from_mem has just been updated
//     stall      FIFO full (registered)
//     overflow   sticky: Enable seen while full (request dropped)
//     count      FIFO occupancy 0..DEPTH
//     bus        memory bus, master side
// -----------------------------------------------------------------------------
module mem_port_req_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Enable,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      to_mem,
    input  logic                   write_rq,
    output logic [DATA_W-1:0]      from_mem,
    output logic                   rd_valid,
    output logic                   stall,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] count,
    mem_port_req_queue_if.master   bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_WAIT_RESP = 1'b1
    } state_t;

    // Registered state
    state_t            state_q,    state_d;
    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [DATA_W-1:0] from_mem_q, from_mem_d;
    logic              rd_valid_q, rd_valid_d;
    logic              stall_q,    stall_d;
    logic              overflow_q, overflow_d;

    // Combinational helpers
    logic   full_s;
    logic   push_s;
    logic   pop_s;
    logic   req_valid_s;
    entry_t head_s;

    // Handshake qualifiers. The head only moves on a pop, so valid and the
    // bus fields are naturally held stable while ready is low.
    always_comb begin
        full_s      = (count_q == CNT_FULL);
        push_s      = Enable && !full_s;
        head_s      = mem_q[rd_ptr_q];
        req_valid_s = (state_q == ST_IDLE) && (count_q != CNT_ZERO);
        pop_s       = req_valid_s && bus.mem_req_ready;
    end

    // FIFO storage, pointers, occupancy and the full/overflow flags
    always_comb begin
        mem_d = mem_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = {write_rq, addr, to_mem};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // push is already blocked when full, so count stays within 0..DEPTH
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // stall tracks the occupancy that the next cycle will see
        stall_d    = (count_d == CNT_FULL);
        overflow_d = overflow_q || (Enable && full_s);
    end

    // Issue FSM: a popped read parks in WAIT_RESP until its response returns
    always_comb begin
        state_d    = state_q;
        from_mem_d = from_mem_q;
        rd_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop_s && !head_s.we) begin
                    state_d = ST_WAIT_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_RESP: begin
                if (bus.mem_resp_valid) begin
                    from_mem_d = bus.mem_resp_rdata;
                    rd_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d    = ST_WAIT_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= CNT_ZERO;
            from_mem_q <= {DATA_W{1'b0}};
            rd_valid_q <= 1'b0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {$bits(entry_t){1'b0}};
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            from_mem_q <= from_mem_d;
            rd_valid_q <= rd_valid_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign from_mem = from_mem_q;
    assign rd_valid = rd_valid_q;
    assign stall    = stall_q;
    assign overflow = overflow_q;
    assign count    = count_q;

    // Bus fields come straight from the FIFO head; they are don't-care while
    // valid is low.
    assign bus.mem_req_valid = req_valid_s;
    assign bus.mem_req_we    = head_s.we;
    assign bus.mem_req_addr  = head_s.addr;
    assign bus.mem_req_wdata = head_s.data;

endmodule

// File: tb/tb_mem_port_req_queue.sv
// -----------------------------------------------------------------------------
// tb_mem_port_req_queue
//   Directed scenarios followed by a randomized phase. A reference model built
//   around a request queue and an "outstanding read" flag predicts every
//   output each cycle. Inputs change 1 time unit after the rising edge.
//   The per-cycle model comparison happens on the falling edge. Directed
//   constant checks are made 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_port_req_queue;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;

    logic              Clock = 1'b0;
    logic              Reset;
    logic              Enable;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] to_mem;
    logic              write_rq;
    logic [DATA_W-1:0] from_mem;
    logic              rd_valid;
    logic              stall;
    logic              overflow;
    logic [2:0]        count;

    mem_port_req_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_port_req_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Enable   (Enable),
        .addr     (addr),
        .to_mem   (to_mem),
        .write_rq (write_rq),
        .from_mem (from_mem),
        .rd_valid (rd_valid),
        .stall    (stall),
        .overflow (overflow),
        .count    (count),
        .bus      (bus)
    );

    always #5 Clock = ~Clock;

    // ---------------- reference model ----------------
    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
    } req_t;

    req_t        q_m[$];
    bit          waiting_m;
    logic [31:0] from_mem_m;
    bit          rd_valid_m;
    bit          stall_m;
    bit          overflow_m;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q_m.delete();
        waiting_m  = 1'b0;
        from_mem_m = 32'h0;
        rd_valid_m = 1'b0;
        stall_m    = 1'b0;
        overflow_m = 1'b0;
    endtask

    // Compare all outputs against the model, advance the model by one edge
    // using the current inputs, then move to just after the edge.
    task automatic cycle();
        bit   exp_valid;
        bit   was_full;
        req_t e;
        @(negedge Clock);
        exp_valid = !waiting_m && (q_m.size() != 0);
        chk("m_valid",    bus.mem_req_valid, exp_valid);
        chk("m_count",    count,             q_m.size());
        chk("m_stall",    stall,             stall_m);
        chk("m_overflow", overflow,          overflow_m);
        chk("m_from_mem", from_mem,          from_mem_m);
        chk("m_rd_valid", rd_valid,          rd_valid_m);
        if (exp_valid) begin
            chk("m_we",    bus.mem_req_we,    q_m[0].we);
            chk("m_addr",  bus.mem_req_addr,  q_m[0].a);
            chk("m_wdata", bus.mem_req_wdata, q_m[0].d);
        end
        if (Reset) begin
            model_clear();
        end else begin
            was_full   = (q_m.size() == DEPTH);
            rd_valid_m = 1'b0;
            if (waiting_m && bus.mem_resp_valid) begin
                from_mem_m = bus.mem_resp_rdata;
                rd_valid_m = 1'b1;
                waiting_m  = 1'b0;
            end
            if (exp_valid && bus.mem_req_ready) begin
                e = q_m.pop_front();
                if (!e.we) waiting_m = 1'b1;
            end
            if (Enable) begin
                if (was_full) overflow_m = 1'b1;
                else q_m.push_back('{we: write_rq, a: addr, d: to_mem});
            end
            stall_m = (q_m.size() == DEPTH);
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic set_req(input logic en, input logic we, input logic [31:0] a, input logic [31:0] d);
        Enable   = en;
        write_rq = we;
        addr     = a;
        to_mem   = d;
    endtask

    initial begin
        Reset              = 1'b1;
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = 32'h0;
        model_clear();

        // 1: reset state
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        chk("rst_from_mem", from_mem,          32'h0);
        chk("rst_stall",    stall,             1'b0);
        chk("rst_overflow", overflow,          1'b0);
        chk("rst_count",    count,             3'd0);
        chk("rst_valid",    bus.mem_req_valid, 1'b0);
        chk("rst_rd_valid", rd_valid,          1'b0);

        // 2: write pass-through
        bus.mem_req_ready = 1'b1;
        set_req(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        cycle();
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        chk("wr_valid", bus.mem_req_valid, 1'b1);
        chk("wr_we",    bus.mem_req_we,    1'b1);
        chk("wr_addr",  bus.mem_req_addr,  32'h10);
        chk("wr_wdata", bus.mem_req_wdata, 32'hDEADBEEF);
        cycle();
        chk("wr_count_after", count,    3'd0);
        chk("wr_no_rd_valid", rd_valid, 1'b0);

        // 3: read with response after three idle cycles
        set_req(1'b1, 1'b0, 32'h20, 32'h0);
        cycle();
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        chk("rd_valid_req", bus.mem_req_valid, 1'b1);
        chk("rd_we",        bus.mem_req_we,    1'b0);
        chk("rd_addr",      bus.mem_req_addr,  32'h20);
        cycle();
        for (int i = 0; i < 3; i++) begin
            chk("rd_wait_novalid", bus.mem_req_valid, 1'b0);
            cycle();
        end
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 32'h1234;
        cycle();
        bus.mem_resp_valid = 1'b0;
        chk("rd_from_mem", from_mem, 32'h1234);
        chk("rd_pulse",    rd_valid, 1'b1);
        cycle();
        chk("rd_pulse_end", rd_valid, 1'b0);
        chk("rd_from_hold", from_mem, 32'h1234);

        // 4: backpressure, full and overflow
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(1'b1, 1'b1, 32'h100 + 32'(i), 32'hA0 + 32'(i));
            cycle();
        end
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        chk("full_count",    count,    3'd4);
        chk("full_stall",    stall,    1'b1);
        chk("full_overflow", overflow, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("hold_addr",  bus.mem_req_addr,  32'h100);
            chk("hold_wdata", bus.mem_req_wdata, 32'hA0);
            cycle();
        end
        bus.mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_addr", bus.mem_req_addr, 32'h100 + 32'(i));
            cycle();
            if (i == 0) chk("drain_stall_clear", stall, 1'b0);
        end
        chk("drain_count", count,             3'd0);
        chk("drain_valid", bus.mem_req_valid, 1'b0);

        // 5: ordering W, W, R, then W held behind the read
        bus.mem_req_ready = 1'b0;
        set_req(1'b1, 1'b1, 32'h200, 32'h1); cycle();
        set_req(1'b1, 1'b1, 32'h201, 32'h2); cycle();
        set_req(1'b1, 1'b0, 32'h202, 32'h0); cycle();
        set_req(1'b1, 1'b1, 32'h203, 32'h4); cycle();
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        bus.mem_req_ready = 1'b1;
        chk("ord0_we", bus.mem_req_we, 1'b1); chk("ord0_addr", bus.mem_req_addr, 32'h200);
        cycle();
        chk("ord1_we", bus.mem_req_we, 1'b1); chk("ord1_addr", bus.mem_req_addr, 32'h201);
        cycle();
        chk("ord2_we", bus.mem_req_we, 1'b0); chk("ord2_addr", bus.mem_req_addr, 32'h202);
        cycle();
        for (int i = 0; i < 3; i++) begin
            chk("ord_blocked_valid", bus.mem_req_valid, 1'b0);
            chk("ord_blocked_count", count,             3'd1);
            cycle();
        end
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 32'hCAFE;
        cycle();
        bus.mem_resp_valid = 1'b0;
        chk("ord_from_mem", from_mem,          32'hCAFE);
        chk("ord3_valid",   bus.mem_req_valid, 1'b1);
        chk("ord3_addr",    bus.mem_req_addr,  32'h203);
        cycle();
        chk("ord_count", count, 3'd0);

        // 6: reset while a read is outstanding; late response is ignored
        set_req(1'b1, 1'b0, 32'h300, 32'h0);
        cycle();
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 32'h55;
        cycle();
        bus.mem_resp_valid = 1'b0;
        chk("rstw_from_mem", from_mem, 32'h0);
        chk("rstw_rd_valid", rd_valid, 1'b0);
        cycle();
        chk("rstw_rd_valid2", rd_valid,          1'b0);
        chk("rstw_valid",     bus.mem_req_valid, 1'b0);

        // randomized phase against the model
        for (int i = 0; i < 600; i++) begin
            Reset              = ($urandom_range(0, 99) == 0);
            Enable             = ($urandom_range(0, 99) < 60);
            write_rq           = $urandom_range(0, 1) == 1;
            addr               = $urandom;
            to_mem             = $urandom;
            bus.mem_req_ready  = ($urandom_range(0, 99) < 50);
            bus.mem_resp_valid = ($urandom_range(0, 99) < 30);
            bus.mem_resp_rdata = $urandom;
            cycle();
        end
        Reset = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
